// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// Holds the FSM state encoding so other lab controllers built on the
// same IDLE/RUN/DONE handshake can reuse identical codes.
package serial_sub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : serial_sub_ctrl_pkg

// File: rtl/serial_sub_ctrl_fs_bit.sv
// Single-bit full subtractor cell (combinational).
// Ports:
//   A     - minuend bit
//   B     - subtrahend bit
//   Brin  - borrow in
//   D     - difference bit, A - B - Brin
//   Brout - borrow out
module serial_sub_ctrl_fs_bit (
    input  logic A,
    input  logic B,
    input  logic Brin,
    output logic D,
    output logic Brout
);

    assign D     = A ^ B ^ Brin;
    // Borrow when B exceeds A, or when the bits are equal and a borrow arrives.
    assign Brout = (~A & B) | (~(A ^ B) & Brin);

endmodule : serial_sub_ctrl_fs_bit

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: D = A - B - Bin, LSB first,
// one bit per clock through a single full-subtractor cell.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   start - request; only sampled in IDLE
//   a, b  - minuend / subtrahend, captured on accepted start
//   bin   - initial borrow-in, captured on accepted start
//   busy  - high while the operation runs
//   done  - one-cycle pulse when d/bout are updated
//   d     - difference, holds the last completed result
//   bout  - final borrow-out (1 = underflow)
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, sr_q, d_q;
    logic [WIDTH-1:0] sr_next;
    logic [CNT_W-1:0] cnt_q;
    logic             brw_q, bout_q, busy_q, done_q;
    logic             busy_d, done_d;
    logic             load, step, last_bit, finish;
    logic             dbit, brout;

    serial_sub_ctrl_fs_bit u_fs_bit (
        .A     (sa_q[0]),
        .B     (sb_q[0]),
        .Brin  (brw_q),
        .D     (dbit),
        .Brout (brout)
    );

    // The new bit enters at the MSB so that after WIDTH shifts the
    // first (LSB) bit has walked down to position 0.
    generate
        if (WIDTH == 1) begin : g_sr_one
            assign sr_next = dbit;
        end else begin : g_sr_wide
            assign sr_next = {dbit, sr_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Output / control decode; busy and done are registered below.
    always_comb begin
        load   = (state_q == ST_IDLE) && start;
        step   = (state_q == ST_RUN);
        finish = step && last_bit;
        busy_d = load || (step && !last_bit);
        done_d = finish;
    end

    // Datapath: operand shifters, borrow flop, counter, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= '0;
            sb_q   <= '0;
            sr_q   <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            brw_q  <= 1'b0;
            bout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (load) begin
                sa_q  <= a;
                sb_q  <= b;
                brw_q <= bin;
                cnt_q <= '0;
            end
            if (step) begin
                sr_q  <= sr_next;
                sa_q  <= sa_q >> 1;
                sb_q  <= sb_q >> 1;
                brw_q <= brout;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (finish) begin
                d_q    <= sr_next;
                bout_q <= brout;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] d8;
    logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
    logic       busy1, done1, bout1, d1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted start yields (a-b-bin) mod 2^W and
    // a borrow flag W edges later, then one edge where start is ignored.
    int          m_left [2];
    logic        m_busy [2], m_done [2], m_bout [2], p_bout [2];
    logic [31:0] m_d [2], p_d [2];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int          w;
            logic [31:0] mask, ia, ib;
            logic        ibin, ist;
            w    = (u == 0) ? 8 : 1;
            mask = (u == 0) ? 32'hFF : 32'h1;
            ia   = (u == 0) ? {24'b0, a8} : {31'b0, a1};
            ib   = (u == 0) ? {24'b0, b8} : {31'b0, b1};
            ibin = (u == 0) ? bin8 : bin1;
            ist  = (u == 0) ? start8 : start1;
            if (!rst_n) begin
                m_left[u] = 0; m_busy[u] = 0; m_done[u] = 0;
                m_d[u] = 0; m_bout[u] = 0;
            end else if (m_left[u] > 0) begin
                m_left[u]--;
                if (m_left[u] == 0) begin
                    m_busy[u] = 0; m_done[u] = 1;
                    m_d[u] = p_d[u]; m_bout[u] = p_bout[u];
                end
            end else if (m_done[u]) begin
                m_done[u] = 0;
            end else if (ist) begin
                p_d[u]    = (ia - ib - {31'b0, ibin}) & mask;
                p_bout[u] = (ia < ib + {31'b0, ibin});
                m_left[u] = w;
                m_busy[u] = 1;
            end
        end
        #1;
        check("m8_busy", {31'b0, busy8}, {31'b0, m_busy[0]});
        check("m8_done", {31'b0, done8}, {31'b0, m_done[0]});
        check("m8_d",    {24'b0, d8},    m_d[0]);
        check("m8_bout", {31'b0, bout8}, {31'b0, m_bout[0]});
        check("m1_busy", {31'b0, busy1}, {31'b0, m_busy[1]});
        check("m1_done", {31'b0, done1}, {31'b0, m_done[1]});
        check("m1_d",    {31'b0, d1},    m_d[1]);
        check("m1_bout", {31'b0, bout1}, {31'b0, m_bout[1]});
    end

    // One 8-bit transaction with literal expectations, including the
    // previous result that must hold mid-run.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                         input logic [7:0] ed, input logic eb, input logic [7:0] hold_d);
        int n, bc;
        bit got;
        n = 0; bc = 0; got = 0;
        @(negedge clk);
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 30; i++) begin
            if (busy8) bc++;
            if (i == 4) check("hold_d", {24'b0, d8}, {24'b0, hold_d});
            if (done8) begin got = 1; n = i; break; end
            @(negedge clk); start8 = 1'b0;
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        check("done_seen", {31'b0, got}, 32'd1);
        check("done_lat", n, 8);
        check("busy_cycles", bc, 8);
        check("op_d", {24'b0, d8}, {24'b0, ed});
        check("op_bout", {31'b0, bout8}, {31'b0, eb});
        $display("op a=%0d b=%0d bin=%0d -> d=%0h bout=%0d", av, bv, bi, d8, bout8);
        @(posedge clk); // DONE -> IDLE edge
    endtask

    logic tt_d [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic tt_b [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int dn;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy8}, 32'd0);
        check("rst_d", {24'b0, d8}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        do_op(8'd100, 8'd37, 1'b0, 8'd63,  1'b0, 8'h00);
        do_op(8'd5,   8'd10, 1'b0, 8'hFB,  1'b1, 8'd63);
        do_op(8'd0,   8'd0,  1'b1, 8'hFF,  1'b1, 8'hFB);
        do_op(8'hFF,  8'hFF, 1'b0, 8'h00,  1'b0, 8'hFF);

        // Start held for 20 edges while operands churn: two acceptances.
        dn = 0;
        @(negedge clk); start8 = 1'b1; a8 = 8'd3; b8 = 8'd4; bin8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8) dn++;
            @(negedge clk);
            a8 = 8'(i * 13); b8 = 8'(i * 7 + 50); bin8 = i[0];
        end
        start8 = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done8) dn++; end
        check("held_dones", dn, 2);
        check("held_last_d", {24'b0, d8}, 32'd3);
        $display("held start: %0d results, last d=%0h", dn, d8);

        // Reset in the middle of a run.
        @(negedge clk); a8 = 8'd200; b8 = 8'd1; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); @(negedge clk); start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        check("arst_busy", {31'b0, busy8}, 32'd0);
        check("arst_done", {31'b0, done8}, 32'd0);
        check("arst_d", {24'b0, d8}, 32'd0);
        check("arst_bout", {31'b0, bout8}, 32'd0);
        $display("reset mid-run applied");
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        dn = 0;
        repeat (12) begin @(posedge clk); #1; if (done8) dn++; end
        check("arst_no_done", dn, 0);

        do_op(8'd9,  8'd3,  1'b0, 8'd6,   1'b0, 8'd0);
        // Back-to-back: second start lands on the first IDLE cycle.
        do_op(8'd50, 8'd20, 1'b0, 8'd30,  1'b0, 8'd6);
        do_op(8'd20, 8'd50, 1'b1, 8'hE1,  1'b1, 8'd30);

        // WIDTH=1 exhaustive truth table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); a1 = i[2]; b1 = i[1]; bin1 = i[0]; start1 = 1'b1;
            @(posedge clk); #1;
            check("w1_busy", {31'b0, busy1}, 32'd1);
            @(negedge clk); start1 = 1'b0;
            @(posedge clk); #1;
            check("w1_done", {31'b0, done1}, 32'd1);
            check("w1_d", {31'b0, d1}, {31'b0, tt_d[i]});
            check("w1_bout", {31'b0, bout1}, {31'b0, tt_b[i]});
            $display("w1 a=%0d b=%0d bin=%0d -> d=%0d bout=%0d", a1, b1, bin1, d1, bout1);
            @(posedge clk);
        end

        repeat (2) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_sub_ctrl
